// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and helpers for the stopwatch control slice.
//   state_t      : control state (RUN / PAUSE / ADJ)
//   presc_width  : bit width of the half-second prescaler for a given clock
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    ADJ   = 2'd2
  } state_t;

  // Width needed to hold 0 .. clk_hz/2-1; never narrower than one bit.
  function automatic int unsigned presc_width(input int unsigned clk_hz);
    return (clk_hz / 2 <= 2) ? 1 : $clog2(clk_hz / 2);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Half-second prescaler producing single-cycle 2 Hz and 1 Hz ticks.
// Parameters:
//   CLK_HZ   : input clock frequency in Hz (multiple of 4)
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous clear of the prescaler and the 1 Hz phase
//   tick_2hz : one-cycle pulse when the prescaler reaches CLK_HZ/2-1
//   tick_1hz : one-cycle pulse on every second tick_2hz
// -----------------------------------------------------------------------------
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_2hz,
  output logic tick_1hz
);

  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned W    = presc_width(CLK_HZ);

  logic [W-1:0] count;
  logic         phase;
  logic         at_max;

  assign at_max   = (count == W'(HALF - 1));
  // A clear cycle restarts the timebase, so no tick may escape from it.
  assign tick_2hz = at_max & ~clr;
  assign tick_1hz = tick_2hz & phase;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      count <= '0;
      phase <= 1'b0;
    end else if (at_max) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Run/pause/adjust controller for a min:sec stopwatch. Issues increment and
// clear pulses to external time counters.
// Optional feature: define STOPWATCH_BLINK_EN to enable the adjust-mode blink
// register; otherwise blink is tied to 0.
// Parameters:
//   CLK_HZ    : input clock frequency in Hz (multiple of 4)
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   pause_btn : debounced level; rising edge toggles run/pause
//   reset_btn : debounced level; rising edge clears the time
//   adj       : 1 = adjust mode
//   sel       : adjust target, 0 = minutes, 1 = seconds
//   sec_inc   : one-cycle seconds increment
//   min_inc   : one-cycle minutes increment
//   clr       : one-cycle clear of all time counters
//   carry_en  : 1 = seconds-to-minutes carry allowed
//   running   : 1 in RUN
//   blink     : blanking phase for the digits being adjusted
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_btn,
  input  logic reset_btn,
  input  logic adj,
  input  logic sel,
  output logic sec_inc,
  output logic min_inc,
  output logic clr,
  output logic carry_en,
  output logic running,
  output logic blink
);

  state_t state, next_state;
  state_t saved_state, next_saved;
  logic   pause_q, reset_q;
  logic   pause_edge, reset_edge;
  logic   tick_2hz, tick_1hz;

  // Button edge detection: one history register per button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      pause_q <= pause_btn;
      reset_q <= reset_btn;
    end
  end

  assign pause_edge = pause_btn & ~pause_q;
  assign reset_edge = reset_btn & ~reset_q;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (reset_edge),
    .tick_2hz (tick_2hz),
    .tick_1hz (tick_1hz)
  );

  // State register, including the state to return to after adjusting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      saved_state <= RUN;
    end else begin
      state       <= next_state;
      saved_state <= next_saved;
    end
  end

  // Next-state logic. A reset edge never changes state; adj takes priority
  // over a simultaneous pause edge.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_saved = saved_state;
    case (state)
      RUN: begin
        if (adj) begin
          next_state = ADJ;
          next_saved = RUN;
        end else if (pause_edge) begin
          next_state = PAUSE;
        end
      end
      PAUSE: begin
        if (adj) begin
          next_state = ADJ;
          next_saved = PAUSE;
        end else if (pause_edge) begin
          next_state = RUN;
        end
      end
      ADJ: begin
        // Pause edges are ignored while adjusting.
        if (!adj) next_state = saved_state;
      end
      default: next_state = RUN;
    endcase
  end

  // Outputs. Ticks are already suppressed by tick_gen in a clear cycle.
  // sel is only consumed when tick_2hz fires, so a mid-period change takes
  // effect on the next tick without a spurious pulse.
  always_comb begin
    sec_inc  = 1'b0;
    min_inc  = 1'b0;
    clr      = reset_edge;
    carry_en = 1'b1;
    running  = 1'b0;
    case (state)
      RUN: begin
        running = 1'b1;
        sec_inc = tick_1hz;
      end
      ADJ: begin
        carry_en = 1'b0;
        if (sel) sec_inc = tick_2hz;
        else     min_inc = tick_2hz;
      end
      default: ;
    endcase
  end

`ifdef STOPWATCH_BLINK_EN
  logic blink_q;

  // Held at 0 outside ADJ and on the exit cycle, so every adjust session
  // starts with digits visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
    end else if (state != ADJ || next_state != ADJ) begin
      blink_q <= 1'b0;
    end else if (tick_2hz) begin
      blink_q <= ~blink_q;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with CLK_HZ = 8 (2 Hz tick every 4 cycles).
// Cycle 0 is the clock period in which rst_n is released; inputs change 1 time
// unit after a rising edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_HZ = 8;
`ifdef STOPWATCH_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic adj = 1'b0;
  logic sel = 1'b0;
  logic sec_inc, min_inc, clr, carry_en, running, blink;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pause_btn (pause_btn),
    .reset_btn (reset_btn),
    .adj       (adj),
    .sel       (sel),
    .sec_inc   (sec_inc),
    .min_inc   (min_inc),
    .clr       (clr),
    .carry_en  (carry_en),
    .running   (running),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0; pause_btn = 1'b0; reset_btn = 1'b0; adj = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pause_btn = 1'b0; reset_btn = 1'b0; sel = 1'b0;
    adj = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (sec_inc !== 1'b0)  begin errors++; $display("FAIL reset sec_inc: got %b want 0", sec_inc); end
    checks++; if (min_inc !== 1'b0)  begin errors++; $display("FAIL reset min_inc: got %b want 0", min_inc); end
    checks++; if (clr !== 1'b0)      begin errors++; $display("FAIL reset clr: got %b want 0", clr); end
    checks++; if (carry_en !== 1'b1) begin errors++; $display("FAIL reset carry_en: got %b want 1", carry_en); end
    checks++; if (running !== 1'b1)  begin errors++; $display("FAIL reset running: got %b want 1", running); end
    checks++; if (blink !== 1'b0)    begin errors++; $display("FAIL reset blink: got %b want 0", blink); end
    adj = 1'b0;
  endtask

  task automatic test_run();
    logic e;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      goto_cycle(c);
      @(negedge clk);
      e = (c == 3 || c == 7 || c == 11 || c == 15 || c == 19 || c == 23);
      checks++; if (dut.u_tick_gen.tick_2hz !== e) begin errors++; $display("FAIL run tick_2hz c=%0d: got %b want %b", c, dut.u_tick_gen.tick_2hz, e); end
      e = (c == 7 || c == 15 || c == 23);
      checks++; if (sec_inc !== e) begin errors++; $display("FAIL run sec_inc c=%0d: got %b want %b", c, sec_inc, e); end
      checks++; if (min_inc !== 1'b0) begin errors++; $display("FAIL run min_inc c=%0d: got %b want 0", c, min_inc); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL run running c=%0d: got %b want 1", c, running); end
    end
  endtask

  task automatic test_pause();
    logic e;
    do_reset();
    for (int c = 0; c < 31; c++) begin
      goto_cycle(c);
      pause_btn = (c >= 9 && c < 29);
      @(negedge clk);
      e = (c < 10);
      checks++; if (running !== e) begin errors++; $display("FAIL pause running c=%0d: got %b want %b", c, running, e); end
      e = (c == 7);
      checks++; if (sec_inc !== e) begin errors++; $display("FAIL pause sec_inc c=%0d: got %b want %b", c, sec_inc, e); end
      checks++; if (clr !== 1'b0) begin errors++; $display("FAIL pause clr c=%0d: got %b want 0", c, clr); end
    end
  endtask

  task automatic test_adj();
    logic e;
    logic in_adj;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      goto_cycle(c);
      adj = (c >= 2 && c <= 17);
      sel = 1'b0;
      @(negedge clk);
      in_adj = (c >= 3 && c <= 18);
      e = (c == 3 || c == 7 || c == 11 || c == 15);
      checks++; if (min_inc !== e) begin errors++; $display("FAIL adj min_inc c=%0d: got %b want %b", c, min_inc, e); end
      e = (c == 23);
      checks++; if (sec_inc !== e) begin errors++; $display("FAIL adj sec_inc c=%0d: got %b want %b", c, sec_inc, e); end
      checks++; if (carry_en !== !in_adj) begin errors++; $display("FAIL adj carry_en c=%0d: got %b want %b", c, carry_en, !in_adj); end
      checks++; if (running !== !in_adj) begin errors++; $display("FAIL adj running c=%0d: got %b want %b", c, running, !in_adj); end
      e = BLINK_EN && ((c >= 4 && c <= 7) || (c >= 12 && c <= 15));
      checks++; if (blink !== e) begin errors++; $display("FAIL adj blink c=%0d: got %b want %b", c, blink, e); end
    end
  endtask

  task automatic test_sel_change();
    logic e;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      goto_cycle(c);
      adj = 1'b1;
      sel = (c <= 8);
      @(negedge clk);
      e = (c == 3 || c == 7);
      checks++; if (sec_inc !== e) begin errors++; $display("FAIL sel sec_inc c=%0d: got %b want %b", c, sec_inc, e); end
      e = (c == 11 || c == 15);
      checks++; if (min_inc !== e) begin errors++; $display("FAIL sel min_inc c=%0d: got %b want %b", c, min_inc, e); end
      e = (c == 0);
      checks++; if (carry_en !== e) begin errors++; $display("FAIL sel carry_en c=%0d: got %b want %b", c, carry_en, e); end
    end
  endtask

  task automatic test_clear();
    logic e;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      goto_cycle(c);
      reset_btn = (c >= 6 && c <= 9);
      @(negedge clk);
      e = (c == 6);
      checks++; if (clr !== e) begin errors++; $display("FAIL clear clr c=%0d: got %b want %b", c, clr, e); end
      e = (c == 14);
      checks++; if (sec_inc !== e) begin errors++; $display("FAIL clear sec_inc c=%0d: got %b want %b", c, sec_inc, e); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL clear running c=%0d: got %b want 1", c, running); end
    end
  endtask

  task automatic test_pause_and_clear();
    logic e;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      goto_cycle(c);
      pause_btn = (c >= 5 && c <= 7);
      reset_btn = (c >= 5 && c <= 7);
      @(negedge clk);
      e = (c == 5);
      checks++; if (clr !== e) begin errors++; $display("FAIL both clr c=%0d: got %b want %b", c, clr, e); end
      e = (c <= 5);
      checks++; if (running !== e) begin errors++; $display("FAIL both running c=%0d: got %b want %b", c, running, e); end
      checks++; if (sec_inc !== 1'b0) begin errors++; $display("FAIL both sec_inc c=%0d: got %b want 0", c, sec_inc); end
    end
  endtask

  task automatic test_adj_from_pause();
    logic e;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      goto_cycle(c);
      pause_btn = (c == 1 || c == 6);
      adj = (c >= 3 && c <= 10);
      sel = 1'b0;
      @(negedge clk);
      e = (c <= 1);
      checks++; if (running !== e) begin errors++; $display("FAIL adjpause running c=%0d: got %b want %b", c, running, e); end
      e = !(c >= 4 && c <= 11);
      checks++; if (carry_en !== e) begin errors++; $display("FAIL adjpause carry_en c=%0d: got %b want %b", c, carry_en, e); end
      e = (c == 7 || c == 11);
      checks++; if (min_inc !== e) begin errors++; $display("FAIL adjpause min_inc c=%0d: got %b want %b", c, min_inc, e); end
      checks++; if (sec_inc !== 1'b0) begin errors++; $display("FAIL adjpause sec_inc c=%0d: got %b want 0", c, sec_inc); end
    end
  endtask

  task automatic test_rst_mid_adj();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      goto_cycle(c);
      adj = 1'b1;
      sel = 1'b0;
    end
    @(negedge clk);
    checks++; if (min_inc !== 1'b1)  begin errors++; $display("FAIL midrst pre min_inc: got %b want 1", min_inc); end
    checks++; if (carry_en !== 1'b0) begin errors++; $display("FAIL midrst pre carry_en: got %b want 0", carry_en); end
    checks++; if (blink !== BLINK_EN) begin errors++; $display("FAIL midrst pre blink: got %b want %b", blink, BLINK_EN); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (sec_inc !== 1'b0)  begin errors++; $display("FAIL midrst sec_inc: got %b want 0", sec_inc); end
    checks++; if (min_inc !== 1'b0)  begin errors++; $display("FAIL midrst min_inc: got %b want 0", min_inc); end
    checks++; if (clr !== 1'b0)      begin errors++; $display("FAIL midrst clr: got %b want 0", clr); end
    checks++; if (carry_en !== 1'b1) begin errors++; $display("FAIL midrst carry_en: got %b want 1", carry_en); end
    checks++; if (running !== 1'b1)  begin errors++; $display("FAIL midrst running: got %b want 1", running); end
    checks++; if (blink !== 1'b0)    begin errors++; $display("FAIL midrst blink: got %b want 0", blink); end
    adj = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    @(negedge clk);
    checks++; if (running !== 1'b1)  begin errors++; $display("FAIL midrst post running: got %b want 1", running); end
    checks++; if (carry_en !== 1'b1) begin errors++; $display("FAIL midrst post carry_en: got %b want 1", carry_en); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_adj();
    test_sel_change();
    test_clear();
    test_pause_and_clear();
    test_adj_from_pause();
    test_rst_mid_adj();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
